// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: latches mult/div operands, drives the shared iteration count and captures the unit result.
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] mult_result,
    input  logic        mult_overflow,
    input  logic        mult_ready,
    input  logic [31:0] div_result,
    input  logic        div_ready,
    output logic [31:0] opA_q,
    output logic [31:0] opB_q,
    output logic [4:0]  count,
    output logic        isDiv,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [4:0] MAX = 5'(MAX_CYCLES);

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] opA_d, opB_d, res_q, res_d;
    logic        is_div_q, is_div_d, exc_q, exc_d, rdy_q, rdy_d;
    logic        start, div_start, div_zero, sel_rdy, done_ok, timeout;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign div_start = ctrl_DIV & ~ctrl_MULT;
    assign div_zero  = div_start & (data_operandB == 32'd0);
    // count==0 is the unit load cycle, so a ready seen there is left over from the previous op
    assign sel_rdy   = is_div_q ? div_ready : mult_ready;
    assign done_ok   = (state_q == RUN) & sel_rdy & (count_q != 5'd0);
    assign timeout   = (state_q == RUN) & ~done_ok & (count_q == MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d = start ? (div_zero ? DONE : RUN) :
                  (state_q == RUN) ? ((done_ok | timeout) ? DONE : RUN) : IDLE;
    end

    always_comb begin
        count_d  = (state_q == RUN && !start && !done_ok && !timeout) ? count_q + 5'd1 : 5'd0;
        opA_d    = start ? data_operandA : opA_q;
        opB_d    = start ? data_operandB : opB_q;
        is_div_d = start ? div_start : is_div_q;
        res_d    = start ? (div_zero ? 32'd0 : res_q) :
                   done_ok ? (is_div_q ? div_result : mult_result) :
                   timeout ? 32'd0 : res_q;
        exc_d    = start ? (div_zero | exc_q) :
                   done_ok ? (~is_div_q & mult_overflow) :
                   timeout ? 1'b1 : exc_q;
        rdy_d    = (state_d == DONE);
    end

    assign count          = count_q;
    assign isDiv          = is_div_q;
    assign busy           = (state_q == RUN);
    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed and randomized operations against a transaction-level model of the sequencer.
module tb_multdiv_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0, data_operandB = '0;
    logic [31:0] mult_result = '0, div_result = '0;
    logic        mult_overflow = 1'b0, mult_ready = 1'b0, div_ready = 1'b0;
    logic [31:0] opA_q, opB_q, data_result;
    logic [4:0]  count;
    logic        isDiv, busy, data_exception, data_resultRDY;
    int n_cmp = 0, n_bad = 0;

    multdiv_sequencer dut (
        .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .mult_result(mult_result), .mult_overflow(mult_overflow), .mult_ready(mult_ready),
        .div_result(div_result), .div_ready(div_ready),
        .opA_q(opA_q), .opB_q(opB_q), .count(count), .isDiv(isDiv), .busy(busy),
        .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    // One operation: the selected unit answers when count==lat (lat>31 means never).
    // Expected RDY edge, result and exception come straight from the operation rules.
    task automatic run_op(input bit d, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit ovf, input bit tail, input string tag);
        logic [31:0] res, xres;
        bit dz, xexc, sel;
        int xe;
        dz   = d && b == 0;
        res  = d ? (b == 0 ? 32'hDEAD_BEEF : a / b) : a * b;
        xe   = dz ? 0 : (lat <= 31 ? lat + 1 : 32);
        xres = (dz || lat > 31) ? 32'd0 : res;
        xexc = dz || lat > 31 || (!d && ovf);
        @(negedge clock);
        ctrl_MULT = !d;
        ctrl_DIV = d ? 1'b1 : 1'($urandom);
        data_operandA = a;
        data_operandB = b;
        mult_result = d ? $urandom : res;
        div_result = d ? res : $urandom;
        mult_overflow = d ? 1'($urandom) : ovf;
        mult_ready = 1'b0;
        div_ready = 1'b0;
        for (int e = 0; e <= xe + int'(tail); e++) begin
            @(posedge clock);
            #1;
            if (e == 0 && !dz) begin
                n_cmp++;
                if (opA_q !== a || opB_q !== b || isDiv !== d) begin
                    n_bad++;
                    $display("FAIL %s latch: got A=%h B=%h div=%b want A=%h B=%h div=%b", tag, opA_q, opB_q, isDiv, a, b, d);
                end
            end
            n_cmp++;
            if (data_resultRDY !== (e == xe)) begin
                n_bad++;
                $display("FAIL %s rdy edge %0d: got %b want %b", tag, e, data_resultRDY, e == xe);
            end
            n_cmp++;
            if (busy !== (e < xe)) begin
                n_bad++;
                $display("FAIL %s busy edge %0d: got %b want %b", tag, e, busy, e < xe);
            end
            n_cmp++;
            if (count !== 5'(e < xe ? e : 0)) begin
                n_bad++;
                $display("FAIL %s count edge %0d: got %0d want %0d", tag, e, count, e < xe ? e : 0);
            end
            if (e >= xe) begin
                n_cmp++;
                if (data_result !== xres || data_exception !== xexc) begin
                    n_bad++;
                    $display("FAIL %s result edge %0d: got %h/%b want %h/%b", tag, e, data_result, data_exception, xres, xexc);
                end
            end
            if (e == xe + int'(tail)) break;
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV = 1'b0;
            sel = (e == lat) || (e == 0);
            mult_ready = d ? 1'($urandom) : sel;
            div_ready = d ? sel : 1'($urandom);
        end
        mult_ready = 1'b0;
        div_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({opA_q, opB_q, count, isDiv, busy, data_result, data_exception, data_resultRDY} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got nonzero outputs A=%h cnt=%0d busy=%b rdy=%b", opA_q, count, busy, data_resultRDY);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_directed;
        run_op(0, 32'd7, -32'sd3, 16, 0, 1, "mult_7x-3");
        n_cmp++;
        if (data_result !== 32'hFFFF_FFEB) begin
            n_bad++;
            $display("FAIL mult_7x-3 value: got %h want FFFFFFEB", data_result);
        end
        run_op(0, 32'h4000_0000, 32'd4, 16, 1, 1, "mult_ovf");
        run_op(1, 32'd100, 32'd0, 5, 0, 1, "div_zero");
        run_op(1, 32'd100, 32'd3, 99, 0, 1, "div_timeout");
        run_op(0, 32'd9, 32'd9, 31, 0, 1, "mult_ready_at_31");
    endtask

    task automatic test_abort;
        @(negedge clock);
        ctrl_DIV = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        div_result = 32'd14;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            n_cmp++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL abort_div_phase cycle %0d: rdy=%b busy=%b want 0/1", i, data_resultRDY, busy);
            end
        end
        n_cmp++;
        if (count !== 5'd5) begin
            n_bad++;
            $display("FAIL abort_count_before: got %0d want 5", count);
        end
        run_op(0, 32'd3, 32'd5, 16, 0, 1, "abort_mult");
    endtask

    task automatic test_reset_mid_op;
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = 32'd11;
        data_operandB = 32'd13;
        repeat (10) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
        end
        n_cmp++;
        if (count !== 5'd9) begin
            n_bad++;
            $display("FAIL rst_mid_count: got %0d want 9", count);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({opA_q, opB_q, count, isDiv, busy, data_result, data_exception, data_resultRDY} !== '0) begin
            n_bad++;
            $display("FAIL rst_async: got A=%h cnt=%0d busy=%b rdy=%b want all 0", opA_q, count, busy, data_resultRDY);
        end
        @(negedge clock);
        reset = 1'b1;
        mult_result = 32'd143;
        for (int i = 0; i < 40; i++) begin
            mult_ready = 1'($urandom);
            div_ready = 1'($urandom);
            @(negedge clock);
            n_cmp++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_after cycle %0d: rdy=%b busy=%b want 0/0", i, data_resultRDY, busy);
            end
        end
        mult_ready = 1'b0;
        div_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        run_op(0, 32'd6, 32'd7, 4, 0, 0, "b2b_first");
        run_op(1, 32'd50, 32'd5, 8, 0, 0, "b2b_second");
        run_op(1, 32'd1, 32'd0, 1, 0, 0, "b2b_divzero");
        run_op(0, 32'd2, 32'd2, 1, 1, 1, "b2b_last");
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            bit d;
            logic [31:0] b;
            d = 1'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            run_op(d, $urandom, b, $urandom_range(1, 34), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_abort;
        test_reset_mid_op;
        test_back_to_back;
        test_random;
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
